// File: rtl/md_unit.sv
// Iterative multiply/divide unit: MULT/MULTU by shift-add and DIV/DIVU by restoring division, into HI/LO.
// Optional MD_DIVZERO_EN: early divide-by-zero exit plus a sticky DIVZ flag.
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HIWE,
    input  logic             LOWE,
    input  logic [WIDTH-1:0] WD,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef MD_DIVZERO_EN
    ,
    output logic             DIVZ
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state, state_next;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sign_a, sign_b;
    logic [2*WIDTH-1:0] acc;
    logic [CNTW-1:0]    cnt;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
`ifdef MD_DIVZERO_EN
    logic               divz_q;
`endif

    // Operand magnitudes; OP[0] marks the signed variants.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One iteration of each algorithm, selected by op_q[1] while running.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]     rem_sh;
    logic               div_fits;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_acc_next;

    // Sign correction applied in FIX.
    logic               res_neg;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latches are inferred.
    always_comb begin
        a_neg = OP[0] & A[WIDTH-1];
        b_neg = OP[0] & B[WIDTH-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;

        // Multiply: add the multiplicand into the upper half, then shift the pair right one bit.
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_acc_next = {mul_sum, acc[WIDTH-1:1]};

        // Divide: the upper half holds the partial remainder, the lower half collects quotient bits.
        rem_sh       = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_fits     = rem_sh >= {1'b0, b_q};
        rem_new      = div_fits ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        div_acc_next = {rem_new, acc[WIDTH-2:0], div_fits};

        res_neg = op_q[0] & (sign_a ^ sign_b);
        prod    = res_neg ? -acc : acc;
        quot    = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = (op_q[0] & sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi  = op_q[1] ? rem  : prod[2*WIDTH-1:WIDTH];
        res_lo  = op_q[1] ? quot : prod[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (START) begin
`ifdef MD_DIVZERO_EN
                    state_next = (OP[1] && B == '0) ? S_FIX : S_RUN;
`else
                    state_next = S_RUN;
`endif
                end
            end
            S_RUN:   if (cnt == CNTW'(WIDTH - 1)) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<='; the synchronous reset wins over every other update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
`ifdef MD_DIVZERO_EN
            divz_q <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            done_q <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (HIWE) hi_q <= WD;
                    if (LOWE) lo_q <= WD;
                    if (START) begin
                        op_q   <= OP;
                        a_q    <= a_mag;
                        b_q    <= b_mag;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef MD_DIVZERO_EN
                        divz_q <= 1'b0;
                        // Preload what the full restoring loop would produce for a zero divisor.
                        if (OP[1] && B == '0) acc <= {a_mag, {WIDTH{1'b1}}};
`endif
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNTW'(1);
                    if (op_q[1]) begin
                        acc <= div_acc_next;
                        a_q <= a_q << 1;
                    end else begin
                        acc <= mul_acc_next;
                        b_q <= b_q >> 1;
                    end
                end
                S_FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
`ifdef MD_DIVZERO_EN
                    divz_q <= op_q[1] && (b_q == '0);
`endif
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != S_IDLE);
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
`ifdef MD_DIVZERO_EN
    assign DIVZ = divz_q;
`endif

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random operations against a 64-bit arithmetic model.
// Follows MD_DIVZERO_EN for the DIVZ port and the short divide-by-zero latency.
module tb_md_unit;

    logic        CLK = 1'b0;
    logic        RST, START, HIWE, LOWE;
    logic [1:0]  OP;
    logic [31:0] A, B, WD;
    logic        BUSY, DONE;
    logic [31:0] HI, LO;
`ifdef MD_DIVZERO_EN
    logic        DIVZ;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    md_unit dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OP    (OP),
        .A     (A),
        .B     (B),
        .HIWE  (HIWE),
        .LOWE  (LOWE),
        .WD    (WD),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .HI    (HI),
        .LO    (LO)
`ifdef MD_DIVZERO_EN
        ,
        .DIVZ  (DIVZ)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference results straight from 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd1: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd2: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hffff_ffff;
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = a[31] ? 32'h0000_0001 : 32'hffff_ffff;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hi = r[31:0];
                    lo = q[31:0];
                end
            end
        endcase
    endfunction

    // Issue one operation and follow it to completion. 'disturb' pokes START/HIWE mid-flight;
    // 'mt_start' raises HIWE/LOWE on the accepting edge.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input bit mt_start);
        logic [31:0] exp_hi, exp_lo;
        int          busy, exp_busy;
        bit          dz;
        model(op, a, b, exp_hi, exp_lo);
        dz       = op[1] && (b == 0);
        exp_busy = 33;
`ifdef MD_DIVZERO_EN
        if (dz) exp_busy = 1;
`endif
        OP    = op;
        A     = a;
        B     = b;
        START = 1'b1;
        HIWE  = mt_start;
        LOWE  = mt_start;
        WD    = 32'hdead_beef;
        step();
        START = 1'b0;
        HIWE  = 1'b0;
        LOWE  = 1'b0;
        A     = $urandom;
        B     = $urandom;
`ifdef MD_DIVZERO_EN
        check($sformatf("%s divz_clear", name), {63'b0, DIVZ}, 64'd0);
`endif
        busy = 0;
        while (BUSY && busy < 40) begin
            busy++;
            START = disturb && (busy == 5);
            HIWE  = disturb && (busy == 5);
            WD    = 32'h0000_1234;
            step();
        end
        START = 1'b0;
        HIWE  = 1'b0;
        check($sformatf("%s busy_cycles", name), 64'(busy), 64'(exp_busy));
        check($sformatf("%s done", name), {63'b0, DONE}, 64'd1);
        check($sformatf("%s hi", name), {32'b0, HI}, {32'b0, exp_hi});
        check($sformatf("%s lo", name), {32'b0, LO}, {32'b0, exp_lo});
`ifdef MD_DIVZERO_EN
        check($sformatf("%s divz", name), {63'b0, DIVZ}, {63'b0, dz});
`endif
        step();
        check($sformatf("%s done_low", name), {63'b0, DONE}, 64'd0);
        check($sformatf("%s idle_after", name), {63'b0, BUSY}, 64'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        RST   = 1'b1;
        START = 1'b0;
        OP    = '0;
        A     = '0;
        B     = '0;
        HIWE  = 1'b0;
        LOWE  = 1'b0;
        WD    = '0;
        step();
        step();
        check("reset busy", {63'b0, BUSY}, 64'd0);
        check("reset done", {63'b0, DONE}, 64'd0);
        check("reset hi", {32'b0, HI}, 64'd0);
        check("reset lo", {32'b0, LO}, 64'd0);
        RST = 1'b0;

        // MTHI/MTLO while idle.
        HIWE = 1'b1;
        WD   = 32'h0000_1234;
        step();
        HIWE = 1'b0;
        check("mthi hi", {32'b0, HI}, 64'h1234);
        check("mthi lo", {32'b0, LO}, 64'h0);
        LOWE = 1'b1;
        WD   = 32'h0000_5678;
        step();
        LOWE = 1'b0;
        check("mtlo lo", {32'b0, LO}, 64'h5678);

        // Reset in the middle of an operation.
        OP    = 2'd0;
        A     = 32'hffff_ffff;
        B     = 32'hffff_ffff;
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (16) step();
        check("midrun busy", {63'b0, BUSY}, 64'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rst_mid busy", {63'b0, BUSY}, 64'd0);
        check("rst_mid done", {63'b0, DONE}, 64'd0);
        check("rst_mid hi", {32'b0, HI}, 64'd0);
        check("rst_mid lo", {32'b0, LO}, 64'd0);
        step();
        check("rst_mid stays idle", {63'b0, BUSY}, 64'd0);

        run_op("multu_max", 2'd0, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 1'b0);
        run_op("mult_neg", 2'd1, 32'hffff_fffd, 32'd7, 1'b0, 1'b0);
        run_op("div_neg", 2'd3, 32'hffff_fff9, 32'd2, 1'b0, 1'b0);
        run_op("divu_small", 2'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("disturbed", 2'd1, 32'h0001_2345, 32'hffff_6789, 1'b1, 1'b0);
        run_op("mult_ovf", 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hffff_ffff, 1'b0, 1'b0);
        run_op("mt_with_start", 2'd2, 32'd1000, 32'd3, 1'b0, 1'b1);
        run_op("divu_zero", 2'd2, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op("div_zero_neg", 2'd3, 32'hffff_fff9, 32'd0, 1'b0, 1'b0);
        run_op("div_zero_pos", 2'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        run_op("div_rem_neg", 2'd3, 32'hffff_ff9c, 32'hffff_fff9, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'hffff_ffff;
                default: r_b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), r_op, r_a, r_b, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit on the execute side of the register file.
- Consumes the two register read operands (rs, rt) and computes MULT, MULTU, DIV and DIVU into dedicated HI/LO registers.
- Serves MTHI and MTLO writes, and drives HI/LO to the writeback mux for MFHI and MFLO.
- Runs multi-cycle with a START/BUSY/DONE handshake; the control unit stalls the PC while BUSY=1.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNTW, 5, iteration counter width; must satisfy 2^CNTW = WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- START  input  1  begin an operation; sampled only when BUSY=0.
- OP  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  WIDTH  rs operand (multiplicand / dividend).
- B  input  WIDTH  rt operand (multiplier / divisor).
- HIWE  input  1  MTHI write enable.
- LOWE  input  1  MTLO write enable.
- WD  input  WIDTH  MTHI/MTLO write data.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse when HI/LO receive a result.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- One clock CLK. RST is synchronous and active-high, and has priority over everything.
- RST=1 at an edge, in any state including mid-operation:
  - State goes to IDLE; counter cleared.
  - HI=0, LO=0, BUSY=0, DONE=0.
  - The operation in flight is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with START=1:
    - Latch OP.
    - For signed ops, latch |A| and |B| plus sign flags; otherwise latch A and B raw.
    - Clear the 2*WIDTH accumulator; set counter=0.
    - Go to RUN; BUSY=1 from the next cycle.
  - START=0: stay in IDLE.
- RUN: one iteration per edge; after the iteration with counter=WIDTH-1, go to FIX.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first.
- FIX edge:
  - Apply sign correction:
    - Signed product is negated if the operand signs differ.
    - Signed quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - Write HI/LO:
    - Multiply: HI = upper half of product, LO = lower half.
    - Divide: HI = remainder, LO = quotient.
  - DONE=1 for exactly this cycle; BUSY=0; go to IDLE.
- Latency:
  - START sampled at edge k.
  - BUSY=1 after edges k through k+32 (33 cycles).
  - Result and DONE visible after edge k+33.
- START with BUSY=1: ignored; no queueing.
- HIWE/LOWE:
  - With BUSY=0: HI or LO ← WD at the edge.
  - With BUSY=1: ignored.
  - In the same edge as an accepted START: the write takes effect and is overwritten at FIX.
- A and B may change after the START edge; the operands are already latched.
- Signed overflow cases:
  - 0x80000000 × 0x80000000 MULT: HI=0x40000000, LO=0.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (no macro), full 33-cycle latency:
  - DIVU: LO=0xFFFFFFFF, HI=A.
  - DIV: magnitude quotient is all-ones, then the sign fix is applied.
    - A≥0: LO=0xFFFFFFFF.
    - A<0: LO=0x00000001.
    - HI=A in both cases.

Optional Feature:
- Macro: MD_DIVZERO_EN.
- Defined:
  - Adds output port DIVZ (1 bit, reset 0).
  - DIV/DIVU with B=0 accepted at edge k:
    - Skips RUN; FIX is entered at edge k.
    - HI/LO, DONE and DIVZ=1 appear after edge k+1 (BUSY high 1 cycle).
    - Results: DIVU gives LO=0xFFFFFFFF, HI=A. DIV gives the sign-fixed quotient as in the no-macro case, HI=A.
  - DIVZ is sticky until RST or the next accepted START.
- Undefined: no DIVZ port; divide-by-zero takes the normal 33-cycle path with the values above.

Test Plan:
- RST mid-RUN (16 cycles after START) -> next cycle: BUSY=0, DONE=0, HI=0, LO=0, state IDLE.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> BUSY for 33 cycles, then DONE pulse with HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=100, B=7 -> LO=14, HI=2.
- START pulsed again and HIWE=1 with WD=0x1234 while BUSY -> both ignored; the first result is intact. HIWE with WD=0x1234 while idle -> HI=0x1234 next cycle.
- DIVU A=5, B=0 -> without macro: 33 busy cycles, LO=0xFFFFFFFF, HI=5. With MD_DIVZERO_EN: result after 2 edges, DIVZ=1.
